// File: rtl/mem_arbiter.sv
// Two-requester round-robin read arbiter in front of a fixed-latency main memory.
// Optional MEM_ARBITER_ADDR_CHECK_EN: compare returned address against the tag.
module mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int LAT    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_hit,
  input  logic              mem_hit_delayed,
  input  logic [ADDR_W-1:0] mem_addr_delayed,
  input  logic [DATA_W-1:0] mem_data,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        out_cnt,
  output logic              err
);

  localparam int D = LAT + 1;

  logic              last;
  logic              gnt0;
  logic              gnt1;
  logic              gnt;
  logic [ADDR_W-1:0] gaddr;
  logic [D-1:0]      tag_v;
  logic [D-1:0]      tag_id;
  logic              fire;
  logic              bad_tag;
  logic              bad_addr;

  // last = 1 means requester 1 won most recently
  always_comb begin
    gnt0  = !reset && req0_valid && (!req1_valid || last);
    gnt1  = !reset && req1_valid && (!req0_valid || !last);
    gnt   = gnt0 || gnt1;
    gaddr = gnt1 ? req1_addr : req0_addr;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign fire    = tag_v[LAT] && !mem_hit_delayed;
  assign bad_tag = (!mem_hit_delayed && !tag_v[LAT])
                || (tag_v[LAT] && mem_hit_delayed);

`ifdef MEM_ARBITER_ADDR_CHECK_EN
  logic [ADDR_W-1:0] tag_a [D];

  assign bad_addr = fire && (tag_a[LAT] != mem_addr_delayed);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) tag_a[i] <= '0;
    end else begin
      for (int i = D - 1; i > 0; i--) tag_a[i] <= tag_a[i-1];
      tag_a[0] <= gaddr;
    end
  end
`else
  logic unused_addr_delayed;

  assign unused_addr_delayed = ^mem_addr_delayed;
  assign bad_addr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      last        <= 1'b1;
      mem_hit     <= 1'b1;
      mem_addr    <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
      out_cnt     <= '0;
      err         <= 1'b0;
    end else begin
      if (gnt) begin
        last     <= gnt1;
        mem_addr <= gaddr;
      end
      mem_hit     <= !gnt;
      tag_v       <= {tag_v[D-2:0], gnt};
      tag_id      <= {tag_id[D-2:0], gnt1};
      resp0_valid <= fire && !tag_id[LAT];
      resp1_valid <= fire && tag_id[LAT];
      if (fire) resp_data <= mem_data;
      unique case ({gnt, fire})
        2'b10:   out_cnt <= out_cnt + 3'd1;
        2'b01:   out_cnt <= out_cnt - 3'd1;
        default: out_cnt <= out_cnt;
      endcase
      if (bad_tag || bad_addr) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// queue-based reference model and a behavioural fixed-latency memory.
module tb_mem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int LAT    = 6;

`ifdef MEM_ARBITER_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_hit;
  logic              mem_hit_delayed;
  logic [ADDR_W-1:0] mem_addr_delayed;
  logic [DATA_W-1:0] mem_data;
  logic              resp0_valid;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp_data;
  logic [2:0]        out_cnt;
  logic              err;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LAT   (LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_ready      (req1_ready),
    .mem_addr        (mem_addr),
    .mem_hit         (mem_hit),
    .mem_hit_delayed (mem_hit_delayed),
    .mem_addr_delayed(mem_addr_delayed),
    .mem_data        (mem_data),
    .resp0_valid     (resp0_valid),
    .resp1_valid     (resp1_valid),
    .resp_data       (resp_data),
    .out_cnt         (out_cnt),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Main memory: LAT-deep delay of hit/address, data looked up on the way out
  logic              hd [LAT];
  logic [ADDR_W-1:0] ad [LAT];
  bit                force_miss;
  bit                corrupt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        hd[i] <= 1'b1;
        ad[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        hd[i] <= hd[i-1];
        ad[i] <= ad[i-1];
      end
      hd[0] <= mem_hit;
      ad[0] <= mem_addr;
    end
  end

  assign mem_hit_delayed  = force_miss ? 1'b0 : hd[LAT-1];
  assign mem_addr_delayed = corrupt ? 15'h7FFF : ad[LAT-1];
  assign mem_data         = memf(ad[LAT-1]);

  typedef struct {
    bit                id;
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;

  exp_t              q[$];
  int                total;
  int                bad;
  int                cyc;
  int                peak;
  bit                mlast;
  logic [ADDR_W-1:0] maddr;
  bit                mhit;
  logic [DATA_W-1:0] mdata;
  bit                merr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit r0;
    bit r1;
    r0 = 1'b0;
    r1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r0    = (q[0].id == 1'b0);
      r1    = (q[0].id == 1'b1);
      mdata = memf(q[0].addr);
      if (corrupt && ACHK) merr = 1'b1;
      void'(q.pop_front());
    end
    chk("resp0_valid", resp0_valid, r0);
    chk("resp1_valid", resp1_valid, r1);
    chk("resp_data", resp_data, mdata);
    chk("mem_hit", mem_hit, mhit);
    chk("mem_addr", mem_addr, maddr);
    chk("out_cnt", out_cnt, 32'(q.size()));
    chk("err", err, merr);
    if (int'(out_cnt) > peak) peak = int'(out_cnt);
  endtask

  task automatic step(input bit v0, input logic [ADDR_W-1:0] a0,
                      input bit v1, input logic [ADDR_W-1:0] a1);
    bit   e0;
    bit   e1;
    exp_t e;
    req0_valid = v0;
    req0_addr  = a0;
    req1_valid = v1;
    req1_addr  = a1;
    #1;
    e0 = v0 && (!v1 || mlast);
    e1 = v1 && (!v0 || !mlast);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    if (e0 || e1) begin
      e.id   = e1;
      e.addr = e1 ? a1 : a0;
      e.due  = cyc + LAT + 2;
      q.push_back(e);
      mlast = e1;
      maddr = e.addr;
      mhit  = 1'b0;
    end else begin
      mhit = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
    chk("rst_mem_hit", mem_hit, 1'b1);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_resp0", resp0_valid, 1'b0);
    chk("rst_resp1", resp1_valid, 1'b0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_out_cnt", out_cnt, '0);
    chk("rst_err", err, 1'b0);
    q.delete();
    mlast = 1'b1;
    maddr = '0;
    mhit  = 1'b1;
    mdata = '0;
    merr  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    peak       = 0;
    force_miss = 1'b0;
    corrupt    = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    do_reset(3);

    // single request on requester 0
    idle(2);
    step(1'b1, 15'h0123, 1'b0, '0);
    idle(LAT + 3);

    // both requesters contending from reset: alternate 0,1,0,1
    do_reset(2);
    for (int i = 0; i < 4; i++)
      step(1'b1, 15'(16'h0100 + i), 1'b1, 15'(16'h0200 + i));
    idle(LAT + 3);

    // ten back-to-back requests on requester 1
    peak = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 15'(16'h0400 + i * 3));
    idle(LAT + 3);
    chk("out_cnt_peak", 32'(peak), 32'd7);

    // reset while requests are in flight
    step(1'b1, 15'h0AAA, 1'b0, '0);
    step(1'b0, '0, 1'b1, 15'h0BBB);
    idle(3);
    do_reset(2);
    idle(LAT + 4);

    // miss from memory with nothing outstanding
    force_miss = 1'b1;
    merr       = 1'b1;
    idle(1);
    force_miss = 1'b0;
    idle(4);
    do_reset(2);

    // wrong address returned with a valid response
    corrupt = 1'b1;
    step(1'b1, 15'h0010, 1'b0, '0);
    idle(LAT + 3);
    corrupt = 1'b0;
    idle(2);
    do_reset(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) != 0, 15'($urandom), ($urandom % 3) != 0,
           15'($urandom));
    idle(LAT + 3);
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15: request address width; matches the main-memory address port.
REQ-002 Parameter DATA_W, default 32: read data width.
REQ-003 Parameter LAT, default 6: main-memory latency in clocks, measured from memory sampling hit/address to hit_delayed/address_req_delayed/outData updating.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1 each  read request from requester 0 / 1.
REQ-007 req0_addr / req1_addr  input  ADDR_W each  request address.
REQ-008 req0_ready / req1_ready  output  1 each  combinational grant; a transfer occurs when valid and ready are both high.
REQ-009 mem_addr  output  ADDR_W  registered address to main memory.
REQ-010 mem_hit  output  1  registered to main memory; 0 = fill request issued, 1 = idle.
REQ-011 mem_hit_delayed  input  1  delayed hit from main memory; 0 = data valid on mem_data.
REQ-012 mem_addr_delayed  input  ADDR_W  delayed address from main memory.
REQ-013 mem_data  input  DATA_W  read data from main memory.
REQ-014 resp0_valid / resp1_valid  output  1 each  registered one-cycle response strobe.
REQ-015 resp_data  output  DATA_W  registered response data, shared by both requesters.
REQ-016 out_cnt  output  3  number of outstanding requests.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 At most one request is granted per cycle; a ready is never high while its valid is low.
REQ-019 Arbitration is round-robin on a last-granted pointer: one valid requester is granted outright; when both are valid, the requester not granted last wins; the pointer updates only on a grant.
REQ-020 On a grant at edge E: mem_addr <= granted address, mem_hit <= 0, and tag stage 0 <= {valid=1, id, addr}; with no grant: mem_hit <= 1, mem_addr holds, and tag stage 0 valid <= 0.
REQ-021 The tag pipeline is LAT+1 stages deep and shifts every cycle, so the tail tag of a request granted at edge E aligns with mem_hit_delayed updated at edge E+LAT.
REQ-022 When mem_hit_delayed==0 and the tail tag is valid: at the next edge, resp<id>_valid <= 1 and resp_data <= mem_data; otherwise both resp valids are 0 and resp_data holds.
REQ-023 End-to-end latency: request accepted in cycle N gives resp_valid high in cycle N+LAT+2 (N+8 at default).
REQ-024 Responses return in grant order; there is no response backpressure, and requesters must accept their strobe.
REQ-025 Back-to-back grants every cycle are supported at full throughput.
REQ-026 out_cnt increments on a grant and decrements on a resp strobe; both in the same cycle leave it unchanged; maximum value is LAT+1 = 7.
REQ-027 err <= 1 if mem_hit_delayed==0 with an invalid tail tag, or if a valid tail tag sees mem_hit_delayed==1; err clears only on reset.

Reset
REQ-028 While reset is high: mem_hit=1, mem_addr=0, all tag stages invalid, resp0_valid=resp1_valid=0, resp_data=0, out_cnt=0, err=0, and the pointer is set so requester 0 wins the first tie.
REQ-029 req0_ready and req1_ready are 0 while reset is high.
REQ-030 Reset mid-operation discards all in-flight requests with no response; main memory shares the same reset.

Configuration
REQ-031 Macro MEM_ARBITER_ADDR_CHECK_EN defined: on each response, the tail-tag address is compared with mem_addr_delayed, and a mismatch sets err.
REQ-032 Macro MEM_ARBITER_ADDR_CHECK_EN undefined: no address is stored in the tag pipeline, mem_addr_delayed is unused, and err covers REQ-027 only.

Verification
REQ-033 Single request: req0 addr 0x0123 accepted in cycle 10 -> mem_hit=0 and mem_addr=0x0123 in cycle 11; resp0_valid=1 with resp_data=mem[0x0123] in cycle 18; out_cnt 1 then 0.
REQ-034 Both requesters valid for 4 cycles from reset -> grants 0,1,0,1; responses 0,1,0,1 in cycles +8..+11; resp1_valid never overlaps resp0_valid.
REQ-035 req1 valid on 10 consecutive cycles, req0 idle -> 10 grants, 10 consecutive resp1 strobes; out_cnt peaks at 7.
REQ-036 Reset asserted 3 cycles after 2 grants -> no resp strobes after reset; out_cnt=0; err=0; mem_hit=1.
REQ-037 Force mem_hit_delayed=0 with an empty tag pipeline -> err=1 next cycle and it stays 1 until reset.
REQ-038 With MEM_ARBITER_ADDR_CHECK_EN, corrupt mem_addr_delayed to 0x7FFF on a valid response for 0x0010 -> err=1; without the macro, err=0.
